// File: rtl/register_file_mp.sv
// Multi-port register file: two registered read ports with write-through bypass,
// two write ports (B wins on collision), a busy scoreboard and a debug tap.
module register_file_mp #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int AW       = $clog2(DEPTH),
   parameter int ZERO_REG = 1,
   parameter int DBG_IDX  = DEPTH - 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             rs_en,
   input  logic [AW-1:0]    rs_addr,
   output logic [WIDTH-1:0] rs_data,
   output logic             rs_busy,
   input  logic             rt_en,
   input  logic [AW-1:0]    rt_addr,
   output logic [WIDTH-1:0] rt_data,
   output logic             rt_busy,
   input  logic             we_a,
   input  logic [AW-1:0]    wa_addr,
   input  logic [WIDTH-1:0] wa_data,
   input  logic             we_b,
   input  logic [AW-1:0]    wb_addr,
   input  logic [WIDTH-1:0] wb_data,
   input  logic             claim,
   input  logic [AW-1:0]    claim_addr,
   output logic [WIDTH-1:0] dbg_data
);

   localparam logic [AW-1:0] DBG_SEL = AW'(DBG_IDX);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   logic [WIDTH-1:0] rs_data_q;
   logic [WIDTH-1:0] rt_data_q;
   logic             rs_busy_q;
   logic             rt_busy_q;

   // Post-edge state; reads sample this so same-cycle writes/claims bypass.
   // Ordering gives port B priority over A, and claim priority over write-clear.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (we_a) begin
         regs_d[wa_addr] = wa_data;
         busy_d[wa_addr] = 1'b0;
      end
      if (we_b) begin
         regs_d[wb_addr] = wb_data;
         busy_d[wb_addr] = 1'b0;
      end
      if (claim) begin
         busy_d[claim_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         regs_d[0] = '0;
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         regs_q    <= '{default: '0};
         busy_q    <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         rs_busy_q <= 1'b0;
         rt_busy_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         if (rs_en) begin
            rs_data_q <= regs_d[rs_addr];
            rs_busy_q <= busy_d[rs_addr];
         end
         if (rt_en) begin
            rt_data_q <= regs_d[rt_addr];
            rt_busy_q <= busy_d[rt_addr];
         end
      end
   end

   assign rs_data  = rs_data_q;
   assign rt_data  = rt_data_q;
   assign rs_busy  = rs_busy_q;
   assign rt_busy  = rt_busy_q;
   assign dbg_data = regs_q[DBG_SEL];

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp with hand-computed expected values.
module tb_register_file_mp;

   logic        clock = 1'b0;
   logic        clk_en = 1'b0;
   logic        reset_n = 1'b1;
   logic        rs_en, rt_en, we_a, we_b, claim;
   logic [2:0]  rs_addr, rt_addr, wa_addr, wb_addr, claim_addr;
   logic [15:0] wa_data, wb_data;
   logic [15:0] rs_data, rt_data, dbg_data;
   logic        rs_busy, rt_busy;

   int vectors = 0;
   int miscompares = 0;

   register_file_mp dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .rs_en      (rs_en),
      .rs_addr    (rs_addr),
      .rs_data    (rs_data),
      .rs_busy    (rs_busy),
      .rt_en      (rt_en),
      .rt_addr    (rt_addr),
      .rt_data    (rt_data),
      .rt_busy    (rt_busy),
      .we_a       (we_a),
      .wa_addr    (wa_addr),
      .wa_data    (wa_data),
      .we_b       (we_b),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .claim      (claim),
      .claim_addr (claim_addr),
      .dbg_data   (dbg_data)
   );

   always #5 if (clk_en) clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rs_en = 0; rt_en = 0; we_a = 0; we_b = 0; claim = 0;
      rs_addr = 0; rt_addr = 0; wa_addr = 0; wb_addr = 0; claim_addr = 0;
      wa_data = 0; wb_data = 0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      idle();
      // async reset with the clock stopped
      #2 reset_n = 0;
      #1;
      check("rst_rs_data", rs_data, 0);
      check("rst_rt_data", rt_data, 0);
      check("rst_rs_busy", rs_busy, 0);
      check("rst_rt_busy", rt_busy, 0);
      check("rst_dbg", dbg_data, 0);
      clk_en = 1;
      tick();
      reset_n = 1;
      rs_en = 1; rs_addr = 3;
      tick();
      check("r3_data", rs_data, 0);
      check("r3_busy", rs_busy, 0);

      // write then read with one-cycle latency, then hold
      idle(); we_a = 1; wa_addr = 5; wa_data = 16'hBEEF;
      tick();
      idle(); rs_en = 1; rs_addr = 5;
      tick();
      check("r5_read", rs_data, 16'hBEEF);
      idle(); we_a = 1; wa_addr = 5; wa_data = 16'h1234;
      tick();
      check("r5_hold", rs_data, 16'hBEEF);
      idle(); we_a = 1; wa_addr = 5; wa_data = 16'h4321; rt_en = 1; rt_addr = 5;
      tick();
      check("r5_bypass_a", rt_data, 16'h4321);

      // collision, B wins, bypassed to read
      idle(); we_a = 1; wa_addr = 2; wa_data = 16'h1111;
      we_b = 1; wb_addr = 2; wb_data = 16'h2222; rt_en = 1; rt_addr = 2;
      tick();
      check("coll_bypass", rt_data, 16'h2222);
      idle(); rs_en = 1; rs_addr = 2;
      tick();
      check("coll_stored", rs_data, 16'h2222);
      check("rt_hold", rt_data, 16'h2222);

      // two ports writing different registers, both read back via bypass
      idle(); we_a = 1; wa_addr = 3; wa_data = 16'h0303;
      we_b = 1; wb_addr = 6; wb_data = 16'h0606;
      rs_en = 1; rs_addr = 3; rt_en = 1; rt_addr = 6;
      tick();
      check("dual_a", rs_data, 16'h0303);
      check("dual_b", rt_data, 16'h0606);

      // scoreboard
      idle(); claim = 1; claim_addr = 4; rt_en = 1; rt_addr = 4;
      tick();
      check("claim_bypass", rt_busy, 1);
      idle(); rs_en = 1; rs_addr = 4;
      tick();
      check("claim_busy", rs_busy, 1);
      idle(); we_a = 1; wa_addr = 4; wa_data = 16'h00AA; rs_en = 1; rs_addr = 4;
      tick();
      check("wr_clear_busy", rs_busy, 0);
      check("wr_clear_data", rs_data, 16'h00AA);
      idle(); claim = 1; claim_addr = 4; we_b = 1; wb_addr = 4; wb_data = 16'h00AA;
      rs_en = 1; rs_addr = 4;
      tick();
      check("claim_wins_busy", rs_busy, 1);
      check("claim_wins_data", rs_data, 16'h00AA);
      idle(); rt_en = 1; rt_addr = 4;
      tick();
      check("claim_wins_held", rt_busy, 1);

      // zero register
      idle(); we_a = 1; wa_addr = 0; wa_data = 16'hFFFF; claim = 1; claim_addr = 0;
      rs_en = 1; rs_addr = 0;
      tick();
      check("r0_bypass_data", rs_data, 0);
      check("r0_bypass_busy", rs_busy, 0);
      idle(); we_b = 1; wb_addr = 0; wb_data = 16'hFFFF;
      tick();
      idle(); rt_en = 1; rt_addr = 0;
      tick();
      check("r0_data", rt_data, 0);
      check("r0_busy", rt_busy, 0);

      // debug tap: no bypass, visible after the edge
      idle(); we_a = 1; wa_addr = 7; wa_data = 16'h7777;
      #1;
      check("dbg_pre", dbg_data, 0);
      tick();
      check("dbg_post", dbg_data, 16'h7777);

      // reset mid-operation
      idle(); we_a = 1; wa_addr = 1; wa_data = 16'h5555; claim = 1; claim_addr = 6;
      tick();
      idle(); rs_en = 1; rs_addr = 1; rt_en = 1; rt_addr = 6;
      tick();
      check("pre_rst_r1", rs_data, 16'h5555);
      check("pre_rst_busy6", rt_busy, 1);
      #2 reset_n = 0;
      #1;
      check("mid_rst_rs", rs_data, 0);
      check("mid_rst_rt_busy", rt_busy, 0);
      check("mid_rst_dbg", dbg_data, 0);
      idle(); we_a = 1; wa_addr = 1; wa_data = 16'h9999; claim = 1; claim_addr = 1;
      rs_en = 1; rs_addr = 1;
      tick();
      check("rst_ignore_rd", rs_data, 0);
      idle();
      #1 reset_n = 1;
      rs_en = 1; rs_addr = 1; rt_en = 1; rt_addr = 6;
      tick();
      check("post_rst_r1", rs_data, 0);
      check("post_rst_r1_busy", rs_busy, 0);
      check("post_rst_busy6", rt_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
